// File: rtl/seq_serializer_piso.sv
// Parallel-in/serial-out transmitter: takes an NBITS word over val/rdy and sends it
// LSB-first, one bit per output transfer, with out_last marking the final bit.
module seq_serializer_piso #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_bit,
  output logic             out_last
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_rdy follows out_rdy combinationally on the last bit so the next word
  // can load in the same edge that retires the current one (no bubble).
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    out_val  = 1'b0;
    out_bit  = 1'b0;
    out_last = 1'b0;
    in_rdy   = 1'b0;
    last_bit = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          shreg_d = in_msg;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_val  = 1'b1;
        out_bit  = shreg_q[0];
        out_last = last_bit;
        in_rdy   = last_bit && out_rdy;
        if (out_rdy) begin
          if (!last_bit) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end else if (in_val) begin
            shreg_d = in_msg;
            cnt_d   = '0;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_serializer_piso.sv
// Bench for seq_serializer_piso (NBITS=8): table vectors, hand sequences and a
// random run, all checked against a queue-of-pending-bits reference model.
module tb_seq_serializer_piso;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_val = 1'b0;
  logic       in_rdy;
  logic [7:0] in_msg = '0;
  logic       out_val;
  logic       out_rdy = 1'b0;
  logic       out_bit;
  logic       out_last;

  int errors = 0;
  int checks = 0;

  seq_serializer_piso #(.NBITS(8)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_bit(out_bit), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted word becomes 8 queued {last,bit} entries.
  logic [1:0] mq[$];
  logic act_val, act_bit, act_last, act_rdy;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [7:0] im, input logic ordy, input logic rn);
    logic ev, eb, el, er;
    @(negedge clk);
    reset = rn; in_val = iv; in_msg = im; out_rdy = ordy;
    #1;
    if (!rn) mq.delete();
    ev = (mq.size() > 0);
    eb = ev ? mq[0][0] : 1'b0;
    el = ev ? mq[0][1] : 1'b0;
    er = (mq.size() == 0) || (mq.size() == 1 && ordy);
    act_val = out_val; act_bit = out_bit; act_last = out_last; act_rdy = in_rdy;
    chk("model_out_val", out_val, ev);
    chk("model_out_bit", out_bit, eb);
    chk("model_out_last", out_last, el);
    chk("model_in_rdy", in_rdy, er);
    @(posedge clk);
    if (rn) begin
      if (ev && ordy) void'(mq.pop_front());
      if (iv && er)
        for (int k = 0; k < 8; k++) mq.push_back({(k == 7), im[k]});
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] msg;
    logic       ordy;
    logic       ev, eb, el, er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [7:0] msg, logic ordy,
                              logic ev, logic eb, logic el, logic er);
    vec_t v;
    v.iv = iv; v.msg = msg; v.ordy = ordy; v.ev = ev; v.eb = eb; v.el = el; v.er = er;
    return v;
  endfunction

  initial begin
    logic [7:0] a5 = 8'hA5;
    // Basic word 0xA5
    tbl.push_back(mk(1, 8'hA5, 1, 0, 0, 0, 1));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 8'h00, 1, 1, a5[k], k == 7, k == 7));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1));
    // Back-to-back 0xFF then 0x00
    tbl.push_back(mk(1, 8'hFF, 1, 0, 0, 0, 1));
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 8'h00, 1, 1, 1, i == 8, i == 8));
    for (int i = 9; i <= 16; i++) tbl.push_back(mk(0, 8'h00, 1, 1, 0, i == 16, i == 16));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1));

    // Reset held for 2 cycles
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    chk("reset_out_val", act_val, 1'b0);
    chk("reset_out_bit", act_bit, 1'b0);
    chk("reset_in_rdy", act_rdy, 1'b1);

    foreach (tbl[i]) begin
      cycle(tbl[i].iv, tbl[i].msg, tbl[i].ordy, 1);
      chk($sformatf("tbl%0d_out_val", i), act_val, tbl[i].ev);
      chk($sformatf("tbl%0d_out_bit", i), act_bit, tbl[i].eb);
      chk($sformatf("tbl%0d_out_last", i), act_last, tbl[i].el);
      chk($sformatf("tbl%0d_in_rdy", i), act_rdy, tbl[i].er);
    end

    // Backpressure on 0x3C: stall 3 cycles while bit 2 (=1) is shown
    cycle(1, 8'h3C, 1, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 1);
    for (int s = 0; s < 3; s++) begin
      cycle(0, 8'h00, 0, 1);
      chk("stall_out_bit", act_bit, 1'b1);
      chk("stall_out_val", act_val, 1'b1);
    end
    for (int k = 2; k < 8; k++) begin
      cycle(0, 8'h00, 1, 1);
      chk("resume_bit", act_bit, (k >= 2 && k <= 5));
    end
    cycle(0, 8'h00, 1, 1);

    // No accept mid-word: 0x55 offered from bit 3 of 0xA5
    cycle(1, 8'hA5, 1, 1);
    for (int k = 0; k < 3; k++) cycle(0, 8'h00, 1, 1);
    for (int k = 3; k < 8; k++) begin
      cycle(1, 8'h55, 1, 1);
      chk("midword_in_rdy", act_rdy, k == 7);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 8'h00, 1, 1);
      chk("second_word_bit", act_bit, ~k[0]);
    end
    cycle(0, 8'h00, 1, 1);

    // Async reset during bit 4 of 0xA5, asserted between edges
    cycle(1, 8'hA5, 1, 1);
    for (int k = 0; k < 4; k++) cycle(0, 8'h00, 1, 1);
    @(negedge clk);
    in_val = 0; out_rdy = 1;
    #1 chk("pre_reset_out_val", out_val, 1'b1);
    #1 reset = 0;
    #1;
    chk("async_out_val", out_val, 1'b0);
    chk("async_out_bit", out_bit, 1'b0);
    chk("async_out_last", out_last, 1'b0);
    mq.delete();
    @(posedge clk);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 1);
    chk("post_reset_out_val", act_val, 1'b0);
    cycle(1, 8'h01, 1, 1);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 8'h00, 1, 1);
      chk("post_reset_bit", act_bit, k == 0);
    end

    // Random traffic including occasional resets
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 24) != 0));
    cycle(0, 8'h00, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
